// File: rtl/axis_marker_strip.sv
// Sync-marker stripper: hunts for a LEN-beat marker and forwards the frame payload through a 2-entry skid buffer.
// Optional status counters are built when AXIS_STRIP_CNT_EN is defined; otherwise frame_cnt/drop_cnt read 0.
module axis_marker_strip #(
  parameter int DATA_W = 8,
  parameter int LEN    = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [DATA_W*LEN-1:0] marker,
  output logic [DATA_W-1:0]     m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  empty_err,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic [CNT_W-1:0]      drop_cnt
);

  localparam int FW = $clog2(LEN + 1);
  localparam int DW = $clog2(LEN + 2);

  typedef enum logic {HUNT, PAYLOAD} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  state_t                      state_q, state_d;
  logic [LEN-1:0][DATA_W-1:0]  win_q, win_d, win_shift;
  logic [FW-1:0]               fill_q, fill_d;
  logic                        err_d;
  logic                        s_acc, full, match, scroll, push, pop;
  beat_t [1:0]                 sk_q;
  logic [1:0]                  sk_cnt;
  beat_t                       in_beat;

  generate
    if (LEN == 1) begin : g_win1
      assign win_shift = s_tdata;
    end else begin : g_winn
      assign win_shift = {win_q[LEN-2:0], s_tdata};
    end
  endgenerate

  assign s_acc   = s_tvalid && s_tready;
  assign full    = (sk_cnt == 2'd2);
  assign scroll  = (fill_q == FW'(LEN));
  // The incoming beat counts toward the fill, so a match needs LEN-1 beats already held.
  assign match   = (({1'b0, fill_q} + 1'b1) >= (FW+1)'(LEN)) && (win_shift == marker);
  assign pop     = m_tvalid && m_tready;
  assign in_beat = '{data: s_tdata, last: s_tlast};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= HUNT;
      win_q     <= '0;
      fill_q    <= '0;
      empty_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      fill_q    <= fill_d;
      empty_err <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    fill_d   = fill_q;
    err_d    = 1'b0;
    push     = 1'b0;
    s_tready = reset && ((state_q == HUNT) || !full);
    case (state_q)
      HUNT: begin
        if (s_acc) begin
          if (match) begin
            win_d  = '0;
            fill_d = '0;
            if (s_tlast) err_d   = 1'b1;
            else         state_d = PAYLOAD;
          end else if (s_tlast) begin
            win_d  = '0;
            fill_d = '0;
          end else begin
            win_d  = win_shift;
            fill_d = scroll ? fill_q : fill_q + 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (s_acc) begin
          push = 1'b1;
          if (s_tlast) state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Head is always entry 0, so the output mux is free and data stays put while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sk_q   <= '0;
      sk_cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (sk_cnt == 2'd0) sk_q[0] <= in_beat;
          else                sk_q[1] <= in_beat;
          sk_cnt <= sk_cnt + 2'd1;
        end
        2'b01: begin
          sk_q[0] <= sk_q[1];
          sk_cnt  <= sk_cnt - 2'd1;
        end
        2'b11: begin
          if (sk_cnt == 2'd2) begin
            sk_q[0] <= sk_q[1];
            sk_q[1] <= in_beat;
          end else begin
            sk_q[0] <= in_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_tdata  = sk_q[0].data;
  assign m_tlast  = sk_q[0].last;
  assign m_tvalid = (sk_cnt != 2'd0);

`ifdef AXIS_STRIP_CNT_EN
  logic [CNT_W-1:0] frame_q, drop_q;
  logic             frame_inc;
  logic [DW-1:0]    drop_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [DW-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // A tlast without a match dumps every held beat plus the current one.
  always_comb begin
    frame_inc = (state_q == PAYLOAD) && s_acc && s_tlast;
    drop_inc  = '0;
    if ((state_q == HUNT) && s_acc) begin
      if (s_tlast && !match) drop_inc = DW'(fill_q) + DW'(1);
      else                   drop_inc = DW'(scroll);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_q <= '0;
      drop_q  <= '0;
    end else begin
      frame_q <= sat_add(frame_q, DW'(frame_inc));
      drop_q  <= sat_add(drop_q, drop_inc);
    end
  end

  assign frame_cnt = frame_q;
  assign drop_cnt  = drop_q;
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_axis_marker_strip.sv
// Scoreboard bench for axis_marker_strip: expected beats are queued as stimulus is driven.
module tb_axis_marker_strip;
  localparam int DW = 8, LEN = 4, CW = 16;
`ifdef AXIS_STRIP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam logic [31:0] MARKER = 32'hA5C30F1E;

  logic              clk, reset;
  logic [DW-1:0]     s_tdata, m_tdata;
  logic              s_tvalid, s_tready, s_tlast;
  logic [DW*LEN-1:0] marker;
  logic              m_tvalid, m_tready, m_tlast, empty_err;
  logic [CW-1:0]     frame_cnt, drop_cnt;

  axis_marker_strip #(.DATA_W(DW), .LEN(LEN), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .marker(marker),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .empty_err(empty_err), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_run, n_fail, out_cnt, ee_cnt;
  logic [8:0] exp_q[$];
  logic       was_stalled;
  logic [8:0] held;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (was_stalled) chk("hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, held});
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) chk("unexp_out", {m_tlast, m_tdata}, 32'h1ff);
        else chk("out", {m_tlast, m_tdata}, exp_q.pop_front());
        out_cnt++;
      end
      if (empty_err) ee_cnt++;
      was_stalled = m_tvalid && !m_tready;
      held        = {m_tlast, m_tdata};
    end else begin
      was_stalled = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send(input logic [7:0] d, input logic l);
    int   t;
    logic acc;
    t = 0;
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    do begin
      @(negedge clk); acc = s_tready;
      @(posedge clk); t++;
    end while (!acc && t < 100);
    if (!acc) chk("send_timeout", 0, 1);
    #1 s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_marker();
    logic [31:0] mk;
    mk = MARKER;
    for (int i = 0; i < 4; i++) send(mk[31-8*i -: 8], 1'b0);
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(posedge clk); t++; end
    chk("drain", exp_q.size(), 0);
    cyc(2);
  endtask

  task automatic chk_cnt(input string tag, input int f, input int d);
    chk({tag, "_frame"}, frame_cnt, CNT_EN ? f : 0);
    chk({tag, "_drop"},  drop_cnt,  CNT_EN ? d : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int o0, e0;
    n_run = 0; n_fail = 0; out_cnt = 0; ee_cnt = 0; was_stalled = 1'b0; held = '0;
    reset = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1; marker = MARKER;
    cyc(2);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_empty_err", empty_err, 0);
    chk_cnt("rst", 0, 0);
    @(negedge clk) reset = 1'b1;
    cyc(1);
    chk("rdy_after_rst", s_tready, 1);

    // 1: basic frame with one leading junk beat
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 1);
    send(8'hFF, 0); send_marker();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 1);
    drain();
    chk_cnt("t1", 1, 1);

    // 2: backpressure for 3 cycles after the second output
    for (int i = 1; i <= 8; i++) push(8'(i), i == 8);
    fork
      begin
        send_marker();
        for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
      end
      begin
        int t, base;
        t = 0; base = out_cnt;
        while (out_cnt < base + 2 && t < 200) begin @(posedge clk); t++; end
        #1 m_tready = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_s_tready", s_tready, 0);
        chk("bp_m_tvalid", m_tvalid, 1);
        @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    drain();
    chk_cnt("t2", 2, 1);

    // 3: overlapping partial marker
    push(8'h44, 1);
    send(8'hA5, 0); send(8'hC3, 0); send(8'hA5, 0); send(8'hC3, 0);
    send(8'h0F, 0); send(8'h1E, 0); send(8'h44, 1);
    drain();
    chk_cnt("t3", 3, 3);

    // 4: marker ends on tlast, then a normal frame
    o0 = out_cnt; e0 = ee_cnt;
    send(8'hA5, 0); send(8'hC3, 0); send(8'h0F, 0); send(8'h1E, 1);
    cyc(3);
    chk("t4_empty_err", ee_cnt - e0, 1);
    chk("t4_no_out", out_cnt - o0, 0);
    push(8'h55, 1);
    send_marker(); send(8'h55, 1);
    drain();
    chk("t4_err_once", ee_cnt - e0, 1);
    chk_cnt("t4", 4, 3);

    // 5: tlast while hunting splits the marker
    o0 = out_cnt;
    send(8'hA5, 0); send(8'hC3, 1); send(8'h0F, 0); send(8'h1E, 0); send(8'h66, 1);
    cyc(3);
    chk("t5_no_out", out_cnt - o0, 0);
    chk_cnt("t5", 4, 8);

    // 6: reset with two payload beats buffered
    m_tready = 1'b0;
    send_marker(); send(8'h10, 0); send(8'h20, 0);
    @(negedge clk);
    chk("t6_full_vld", m_tvalid, 1);
    chk("t6_full_rdy", s_tready, 0);
    reset = 1'b0;
    #1;
    chk("t6_rst_vld", m_tvalid, 0);
    chk("t6_rst_rdy", s_tready, 0);
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    cyc(1);
    chk_cnt("t6_rst", 0, 0);
    o0 = out_cnt;
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 1);
    cyc(3);
    chk("t6_no_out", out_cnt - o0, 0);
    push(8'h77, 1);
    send_marker(); send(8'h77, 1);
    drain();
    chk_cnt("t6", 1, 3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_marker_strip.md
# axis_marker_strip

Downstream stage for the marker-inserting AXI4-Stream packer. Consumes a byte stream in which each frame is preceded by a LEN-beat sync marker, hunts for the marker, discards it and anything before it, and forwards the payload with AXI4-Stream handshakes. A frame ends on s_tlast. Output is registered through a 2-entry skid buffer for full throughput under backpressure.

## Interface
- DATA_W, 8, beat width in bits
- LEN, 4, marker length in beats (≥1)
- CNT_W, 16, width of status counters

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- s_tdata  in  DATA_W  input beat
- s_tvalid  in  1  input valid
- s_tready  out  1  input ready
- s_tlast  in  1  last beat of input frame
- marker  in  DATA_W*LEN  sync marker; MSB beat is transmitted first; quasi-static
- m_tdata  out  DATA_W  payload beat
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- m_tlast  out  1  last payload beat of frame
- empty_err  out  1  one-cycle pulse: marker completed on a beat carrying s_tlast
- frame_cnt  out  CNT_W  frames forwarded (see Configuration)
- drop_cnt  out  CNT_W  beats discarded while hunting, marker beats excluded

## Operation
- Input beat accepted when s_tvalid && s_tready.
- FSM states: HUNT, PAYLOAD.
- HUNT: s_tready=1. Each accepted beat shifts into an LEN-beat window, newest at LSB. Match when window == marker and at least LEN beats have been received since entering HUNT.
  - On a match, go to PAYLOAD.
  - Overlapping partial matches are detected naturally. Example: A5 C3 A5 C3 0F 1E matches A5C30F1E.
  - Beats that scroll out of the window without forming a match increment drop_cnt.
  - Accepted beat with s_tlast in HUNT:
    - clears the window and the fill count;
    - any buffered non-matching beats count as dropped;
    - if that beat completes a match, empty_err pulses, no output is produced, and the FSM stays in HUNT.
- PAYLOAD: s_tready = skid buffer not full. Accepted beats are pushed into the skid buffer with their s_tlast.
  - Marker patterns inside the payload are forwarded unchanged.
  - Accepted beat with s_tlast: return to HUNT with the window cleared, and increment frame_cnt.
- Skid buffer: 2 entries, FIFO order. The head drives m_tdata, m_tlast and m_tvalid. An entry pops on m_tvalid && m_tready. Push and pop in the same cycle are both honoured.
- Counters saturate at all-ones.

## Timing
- Reset (async assert, sync release) sets:
  - m_tvalid=0, m_tdata=0, m_tlast=0, empty_err=0, counters=0;
  - s_tready=0 while reset is low;
  - FSM=HUNT, window cleared, skid buffer emptied.
- Reset mid-frame discards buffered beats. The next frame needs a fresh marker.
- First cycle after release: s_tready=1.
- Latency: a payload beat accepted at edge N appears on m_tdata/m_tvalid after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle when m_tready=1.
- With m_tready=0, at most 2 payload beats are accepted before s_tready drops. s_tready rises the cycle after a pop.
- m_tdata and m_tlast are held stable while m_tvalid && !m_tready.
- m_tvalid never deasserts without a handshake.
- The window-to-PAYLOAD transition takes effect on the beat after the last marker beat. No bubble is added on s_tready.
- empty_err is asserted in the cycle after the offending beat is accepted.

## Configuration
- AXIS_STRIP_CNT_EN defined: frame_cnt and drop_cnt are implemented as described.
- AXIS_STRIP_CNT_EN undefined: counter registers are not built, and frame_cnt/drop_cnt drive constant 0. Datapath, FSM and empty_err are unchanged.

## Test plan
All scenarios use DATA_W=8, LEN=4, marker=32'hA5C30F1E, with AXIS_STRIP_CNT_EN defined.
1. Basic frame. Input: FF A5 C3 0F 1E 11 22 33(last), m_tready=1. Required: m_tdata 11,22,33; m_tlast only on 33; frame_cnt=1; drop_cnt=1.
2. Backpressure. Input: marker + 8 payload bytes 01..08(last), with m_tready=0 for 3 cycles after the second output. Required: s_tready low within 2 accepted beats; output 01..08 in order, no loss or duplication; m_tdata held stable while stalled.
3. Overlap. Input: A5 C3 A5 C3 0F 1E 44(last). Required: single output 44 with m_tlast; drop_cnt=2.
4. Empty frame. Input: A5 C3 0F 1E(last on 1E), then a normal frame with payload 55(last). Required: empty_err pulses once; no output for the first frame; second frame outputs 55, last.
5. Tlast in hunt. Input: A5 C3(last) then 0F 1E 66(last). Required: no match, no output; drop_cnt=5.
6. Reset mid-operation. Pull reset low during PAYLOAD with 2 beats buffered. Required: m_tvalid=0 immediately. After release, payload without a marker is dropped; a new marker + 77(last) outputs 77.
